toggle_rx: RTL and testbench
============================

# toggle_rx

Receiving end of the toggle-signalling scheme used by the `tff` toggle flip-flop: the sender flips a level once per event, and this block turns each level change back into a one-cycle pulse. It synchronises the incoming toggle level, detects every transition, and queues events in a saturating pending counter. The queue drains through a valid/ready handshake, and a sticky overflow flag reports events lost while the counter was full. It sits downstream of any toggle-based event source, whether in the same or a different clock domain.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `tgl_in`, minimum 1.
- `CNT_W`, default 4: pending-counter width; capacity is 2^CNT_W−1 events.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tgl_in`  in  1  toggle level from the sender; one event per transition.
- `clr`  in  1  synchronous clear of the pending counter and the overflow flag.
- `pulse`  out  1  one-cycle strobe per detected transition.
- `ev_valid`  out  1  high while the pending count is non-zero.
- `ev_ready`  in  1  consumer accepts one event when `ev_valid && ev_ready`.
- `ev_count`  out  CNT_W  current pending count.
- `overflow`  out  1  sticky; set when an edge arrives while the count is saturated.

## Operation
- `tgl_in` passes through an SYNC_STAGES-flop chain `s[0..N-1]`. A register `prev` holds the previous value of `s[N-1]`.
- Edge term is `e = s[N-1] ^ prev`. On each clock: `prev <= s[N-1]` and `pulse <= e`.
- Pending counter `cnt` updates as follows, in priority order:
  - `clr` forces 0.
  - `e` and pop (`ev_valid && ev_ready`) together leave `cnt` unchanged. This holds even at saturation, so no overflow is raised in that case.
  - `e` alone with `cnt < 2^CNT_W−1` increments `cnt`.
  - `e` alone with `cnt` saturated leaves `cnt` unchanged and sets `overflow`.
  - Pop alone decrements `cnt`.
- `ev_valid = (cnt != 0)` and `ev_count = cnt`. Both are combinational from the register.
- `ev_ready` while `ev_valid` is low is ignored; `cnt` never underflows.
- `overflow` stays set until `clr` or reset. If `clr` and a saturating edge coincide, `clr` wins.
- `pulse` fires for every transition regardless of counter state or `clr`.

## Timing
- Reset values: all sync flops, `prev`, `pulse`, `cnt` and `overflow` are 0. Consequently `ev_valid` = 0 and `ev_count` = 0.
- Reset asserted mid-operation clears everything immediately. In-flight transitions are discarded.
- If `tgl_in` = 1 at reset release, it counts as one event. This matches a sender whose level resets to 0.
- Latency:
  - Call the edge that first samples a new `tgl_in` level edge 0.
  - `pulse` and the `cnt` increment take effect at edge SYNC_STAGES.
  - `pulse` stays high for exactly one cycle.
  - With the default depth of 2, `ev_valid` rises after edge 2.
- Throughput is one transition per cycle. A `tgl_in` toggling every cycle gives a continuous `pulse`. The sender must hold each level for at least one `clk` period, otherwise transitions are lost silently.
- Pop takes effect at the accepting edge; `ev_valid` drops after the edge that takes `cnt` from 1 to 0.

## Structure
- Shared package `toggle_pkg`:
  - default constants `TGL_SYNC_STAGES_DEF` = 2 and `TGL_CNT_W_DEF` = 4;
  - a `cnt_op_t` enum with values NONE, INC, DEC and HOLD_SAT, which the counter next-state logic decodes.
- One natural sub-module, `sync_chain`: parameterised depth, async active-low reset to 0, a 1-bit input and a 1-bit output. It is reused by future toggle-domain blocks.
- Counter, edge detection and flag logic stay in `toggle_rx`.

## Test plan
- Reset, then toggle `tgl_in` 0→1 at edge 0 → `pulse` high for one cycle after edge 2; `ev_count` = 1; `ev_valid` = 1.
- Drive 5 transitions one cycle apart with `ev_ready` = 0 → 5 consecutive `pulse` cycles; `ev_count` = 5. Then `ev_ready` = 1 for 5 cycles → count steps 4,3,2,1,0; `ev_valid` drops.
- Drive 17 transitions with `ev_ready` = 0 (default width) → `ev_count` saturates at 15, `overflow` = 1, and `pulse` still fires 17 times. Then `clr` → count 0, `overflow` 0.
- With `cnt` = 15, an edge arrives in the same cycle as a pop → `cnt` stays 15 and `overflow` stays 0.
- With `cnt` = 3 and a transition still inside the synchroniser, assert `rst_n` low → all outputs 0 at once. After release, no spurious `pulse` occurs while `tgl_in` is 0.
- Release reset with `tgl_in` held at 1 → exactly one `pulse` and `ev_count` = 1.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared definitions for toggle-signalling blocks.
//   TGL_SYNC_STAGES_DEF : default synchroniser depth
//   TGL_CNT_W_DEF       : default pending-counter width
//   cnt_op_t            : pending-counter operation decoded each cycle
package toggle_pkg;

  localparam int TGL_SYNC_STAGES_DEF = 2;
  localparam int TGL_CNT_W_DEF       = 4;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    INC      = 2'd1,
    DEC      = 2'd2,
    HOLD_SAT = 2'd3
  } cnt_op_t;

endpackage : toggle_pkg

// File: rtl/sync_chain.sv
// Multi-flop level synchroniser.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, all stages to 0
//   din   : asynchronous level input
//   dout  : synchronised level, DEPTH cycles behind din
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] s_q;
  logic [DEPTH-1:0] s_d;

  always_comb begin
    s_d    = s_q;
    s_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign dout = s_q[DEPTH-1];

endmodule : sync_chain

// File: rtl/toggle_rx.sv
// Toggle-signalling receiver: turns each level change on tgl_in into a
// one-cycle pulse and queues the events in a saturating pending counter
// drained through a valid/ready handshake.
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   tgl_in   : toggle level from the sender, one event per transition
//   clr      : synchronous clear of pending count and overflow flag
//   pulse    : one-cycle strobe per detected transition
//   ev_valid : pending count is non-zero
//   ev_ready : consumer accepts one event when ev_valid && ev_ready
//   ev_count : current pending count
//   overflow : sticky, an event was lost while the count was saturated
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = TGL_SYNC_STAGES_DEF,
  parameter int CNT_W       = TGL_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgl_in,
  input  logic             clr,
  output logic             pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sync_lvl;
  logic             prev_q, prev_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             edge_det;
  logic             pop;
  cnt_op_t          cnt_op;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tgl_in),
    .dout  (sync_lvl)
  );

  assign edge_det = sync_lvl ^ prev_q;
  assign pop      = ev_valid & ev_ready;

  // An edge and a pop in the same cycle cancel, even when saturated, so
  // that case never counts as a lost event.
  always_comb begin
    cnt_op = NONE;
    if (edge_det && pop) begin
      cnt_op = NONE;
    end else if (edge_det) begin
      cnt_op = (cnt_q == CNT_MAX) ? HOLD_SAT : INC;
    end else if (pop) begin
      cnt_op = DEC;
    end
  end

  always_comb begin
    prev_d  = sync_lvl;
    pulse_d = edge_det;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      case (cnt_op)
        INC:      cnt_d = cnt_q + CNT_W'(1);
        DEC:      cnt_d = cnt_q - CNT_W'(1);
        HOLD_SAT: ovf_d = 1'b1;
        default:  cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse    = pulse_q;
  assign ev_valid = (cnt_q != '0);
  assign ev_count = cnt_q;
  assign overflow = ovf_q;

endmodule : toggle_rx

// File: tb/tb_toggle_rx.sv
module tb_toggle_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgl_in;
  logic       clr;
  logic       pulse;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  toggle_rx #(
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl_in   (tgl_in),
    .clr      (clr),
    .pulse    (pulse),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_count (ev_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int run;
  int max_run;

  initial begin
    rst_n    = 1'b0;
    tgl_in   = 1'b0;
    clr      = 1'b0;
    ev_ready = 1'b0;
    tick();
    tick();
    chk("rst_pulse", pulse, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // single transition: pulse after edge 2
    tgl_in = 1'b1;
    tick();
    tick();
    chk("t1_pulse_early", pulse, 0);
    chk("t1_valid_early", ev_valid, 0);
    tick();
    chk("t1_pulse", pulse, 1);
    chk("t1_count", ev_count, 1);
    chk("t1_valid", ev_valid, 1);
    tick();
    chk("t1_pulse_one_cycle", pulse, 0);
    ev_ready = 1'b1;
    tick();
    chk("t1_pop_count", ev_count, 0);
    chk("t1_pop_valid", ev_valid, 0);
    tick();
    chk("t1_no_underflow", ev_count, 0);
    ev_ready = 1'b0;

    // five back-to-back transitions
    pulses = 0; run = 0; max_run = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) tgl_in = ~tgl_in;
      tick();
      if (pulse) begin
        pulses++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    chk("t2_pulses", pulses, 5);
    chk("t2_consecutive", max_run, 5);
    chk("t2_count", ev_count, 5);
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_drain", ev_count, 4 - i);
    end
    chk("t2_valid_drop", ev_valid, 0);
    ev_ready = 1'b0;

    // 17 transitions saturate the counter
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 17) tgl_in = ~tgl_in;
      tick();
      if (pulse) pulses++;
      if (i == 16) chk("t3_no_ovf_at_15", overflow, 0);
    end
    chk("t3_pulses", pulses, 17);
    chk("t3_count_sat", ev_count, 15);
    chk("t3_ovf", overflow, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_clr_count", ev_count, 0);
    chk("t3_clr_ovf", overflow, 0);

    // edge coinciding with pop at saturation
    for (int i = 0; i < 20; i++) begin
      if (i < 15) tgl_in = ~tgl_in;
      tick();
    end
    chk("t4_count_15", ev_count, 15);
    chk("t4_ovf_pre", overflow, 0);
    tgl_in = ~tgl_in;
    tick();
    tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("t4_pulse", pulse, 1);
    chk("t4_count_hold", ev_count, 15);
    chk("t4_ovf_clear", overflow, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr", ev_count, 0);

    // async reset with a transition in flight
    for (int i = 0; i < 6; i++) begin
      if (i < 3) tgl_in = ~tgl_in;
      tick();
    end
    chk("t5_count_3", ev_count, 3);
    tgl_in = ~tgl_in;
    tick();
    #2;
    rst_n  = 1'b0;
    tgl_in = 1'b0;
    #1;
    chk("t5_async_pulse", pulse, 0);
    chk("t5_async_valid", ev_valid, 0);
    chk("t5_async_count", ev_count, 0);
    chk("t5_async_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse) pulses++;
    end
    ev_ready = 1'b0;
    chk("t5_no_spurious", pulses, 0);
    chk("t5_count", ev_count, 0);

    // reset released with tgl_in high counts one event
    rst_n  = 1'b0;
    tgl_in = 1'b1;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pulse) pulses++;
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_count", ev_count, 1);
    chk("t6_valid", ev_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_toggle_rx
